// File: rtl/aes_sbox_unit.sv
// aes_sbox_unit: sequenced LANES-wide AES S-box (forward/inverse) over a 32-bit word.
// Define AES_SBOX_SM4_EN to add the sm4_i port and SM4 top/bottom layers.
module aes_sbox_unit #(
    parameter int LANES = 4,
    parameter int PIPE  = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid_i,
    output logic        in_ready_o,
    input  logic        inv_i,
`ifdef AES_SBOX_SM4_EN
    input  logic        sm4_i,
`endif
    input  logic [31:0] data_i,
    output logic        out_valid_o,
    input  logic        out_ready_i,
    output logic [31:0] data_o
);
    localparam int STEPS = 4 / LANES;
    localparam logic [2:0] LAST = 3'(STEPS * (1 + PIPE) - 1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t      state;
    logic [2:0]  cnt;
    logic [31:0] op;
    logic        inv_q, accept, wr;
    logic [1:0]  step;
    logic [1:0]  idx [LANES];
    logic [7:0]  bot [LANES];
`ifdef AES_SBOX_SM4_EN
    logic        sm4_q;
`endif

    function automatic logic [7:0] rol(input logic [7:0] x, input int n);
        return (x << n) | (x >> (8 - n));
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x;
        p = '0;
        x = a;
        for (int i = 0; i < 8; i++) begin
            p = b[i] ? p ^ x : p;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // x^254 by square-and-multiply; maps 0 to 0 as the S-box requires
    function automatic logic [7:0] ginv(input logic [7:0] x);
        logic [7:0] r, p;
        r = 8'h01;
        p = x;
        for (int i = 0; i < 7; i++) begin
            p = gmul(p, p);
            r = gmul(r, p);
        end
        return r;
    endfunction

    function automatic logic [7:0] aff(input logic [7:0] x);
        return x ^ rol(x, 1) ^ rol(x, 2) ^ rol(x, 3) ^ rol(x, 4) ^ 8'h63;
    endfunction

    function automatic logic [7:0] iaff(input logic [7:0] x);
        return rol(x, 1) ^ rol(x, 3) ^ rol(x, 6) ^ 8'h05;
    endfunction

`ifdef AES_SBOX_SM4_EN
    function automatic logic [7:0] gpow(input logic [7:0] x, input int n);
        logic [7:0] r;
        r = 8'h01;
        for (int i = 0; i < n; i++) r = gmul(r, x);
        return r;
    endfunction

    function automatic logic [7:0] mapply(input logic [63:0] m, input logic [7:0] x);
        logic [7:0] y;
        y = '0;
        for (int i = 0; i < 8; i++) y = x[i] ? y ^ m[8*i +: 8] : y;
        return y;
    endfunction

    // SM4 field (x^8+x^7+x^6+x^5+x^4+x^2+1) mapped into the AES field via a root of its polynomial
    function automatic logic [63:0] phi_mat();
        logic [7:0]  b, p;
        logic [63:0] m;
        b = '0;
        m = '0;
        for (int c = 2; c < 256; c++)
            if (b == '0 && (gpow(8'(c), 8) ^ gpow(8'(c), 7) ^ gpow(8'(c), 6) ^ gpow(8'(c), 5)
                            ^ gpow(8'(c), 4) ^ gpow(8'(c), 2)) == 8'h01)
                b = 8'(c);
        p = 8'h01;
        for (int i = 0; i < 8; i++) begin
            m[8*i +: 8] = p;
            p = gmul(p, b);
        end
        return m;
    endfunction

    function automatic logic [63:0] phi_inv_mat(input logic [63:0] m);
        logic [63:0] r;
        r = '0;
        for (int j = 0; j < 8; j++)
            for (int z = 0; z < 256; z++)
                if (mapply(m, 8'(z)) == 8'(1 << j)) r[8*j +: 8] = 8'(z);
        return r;
    endfunction

    function automatic logic [7:0] sm4_aff(input logic [7:0] x);
        logic [7:0] y;
        y = '0;
        for (int i = 0; i < 8; i++) y[7-i] = ^(x & rol(8'he5, 8 - i));
        return y ^ 8'hd3;
    endfunction

    localparam logic [63:0] PHI     = phi_mat();
    localparam logic [63:0] PHI_INV = phi_inv_mat(PHI);
`endif

    assign step       = (PIPE != 0) ? cnt[2:1] : cnt[1:0];
    assign wr         = (PIPE == 0) || cnt[0];
    assign in_ready_o = !reset && (state == IDLE || (state == DONE && out_ready_i));
    assign accept     = in_valid_i && in_ready_o;

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        logic [7:0] lin, top, mid, mid_q, mid_b;
        assign idx[g] = 2'(int'(step) * LANES + g);
        assign lin    = op[8*idx[g] +: 8];
`ifdef AES_SBOX_SM4_EN
        assign top    = sm4_q ? mapply(PHI, sm4_aff(lin)) : inv_q ? iaff(lin) : lin;
`else
        assign top    = inv_q ? iaff(lin) : lin;
`endif
        assign mid    = ginv(top);
        always_ff @(posedge clk) mid_q <= reset ? '0 : mid;
        assign mid_b  = (PIPE != 0) ? mid_q : mid;
`ifdef AES_SBOX_SM4_EN
        assign bot[g] = sm4_q ? sm4_aff(mapply(PHI_INV, mid_b)) : inv_q ? mid_b : aff(mid_b);
`else
        assign bot[g] = inv_q ? mid_b : aff(mid_b);
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            cnt         <= '0;
            op          <= '0;
            inv_q       <= 1'b0;
`ifdef AES_SBOX_SM4_EN
            sm4_q       <= 1'b0;
`endif
            out_valid_o <= 1'b0;
            data_o      <= '0;
        end else if (accept) begin
            state       <= BUSY;
            cnt         <= '0;
            op          <= data_i;
            inv_q       <= inv_i;
`ifdef AES_SBOX_SM4_EN
            sm4_q       <= sm4_i;
`endif
            out_valid_o <= 1'b0;
        end else if (state == DONE && out_ready_i) begin
            state       <= IDLE;
            out_valid_o <= 1'b0;
        end else if (state == BUSY) begin
            cnt <= cnt + 3'd1;
            for (int i = 0; i < LANES; i++)
                if (wr) data_o[8*idx[i] +: 8] <= bot[i];
            if (cnt == LAST) begin
                state       <= DONE;
                out_valid_o <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_aes_sbox_unit.sv
// tb_aes_sbox_unit: vector table, exhaustive byte sweep and random words against a search-based
// S-box model, on three lane/pipeline configurations side by side.
module tb_aes_sbox_unit;
    localparam int N = 3;
    localparam int LN  [N] = '{4, 1, 2};
    localparam int PP  [N] = '{0, 1, 1};
    localparam int LAT [N] = '{1, 8, 4};

    logic        clk = 1'b0;
    logic        rst [N];
    logic        in_valid [N];
    logic        in_ready [N];
    logic        inv [N];
    logic        out_valid [N];
    logic        out_ready [N];
    logic [31:0] din [N];
    logic [31:0] dout [N];
`ifdef AES_SBOX_SM4_EN
    logic        sm4 [N];
`endif
    int          n_cmp = 0;
    int          n_bad = 0;
    logic [7:0]  fwd [256];
    logic [7:0]  rev [256];

    typedef struct {
        logic        iv;
        logic [31:0] w;
        logic [31:0] exp;
    } vec_t;
    vec_t tbl [6];

    always #5 clk = ~clk;

    for (genvar g = 0; g < N; g++) begin : g_dut
        aes_sbox_unit #(.LANES(LN[g]), .PIPE(PP[g])) u (
            .clk         (clk),
            .reset       (rst[g]),
            .in_valid_i  (in_valid[g]),
            .in_ready_o  (in_ready[g]),
            .inv_i       (inv[g]),
`ifdef AES_SBOX_SM4_EN
            .sm4_i       (sm4[g]),
`endif
            .data_i      (din[g]),
            .out_valid_o (out_valid[g]),
            .out_ready_i (out_ready[g]),
            .data_o      (dout[g])
        );
    end

    // Polynomial product reduced by long division modulo x^8+x^4+x^3+x+1
    function automatic logic [7:0] mul(input logic [7:0] a, input logic [7:0] b);
        logic [14:0] p;
        p = '0;
        for (int i = 0; i < 8; i++) if (b[i]) p ^= 15'(a) << i;
        for (int i = 14; i >= 8; i--) if (p[i]) p ^= 15'h11b << (i - 8);
        return p[7:0];
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] y, s, c;
        y = '0;
        c = 8'h63;
        for (int k = 1; k < 256; k++) if (mul(x, 8'(k)) == 8'h01) y = 8'(k);
        for (int i = 0; i < 8; i++)
            s[i] = y[i] ^ y[(i+4)%8] ^ y[(i+5)%8] ^ y[(i+6)%8] ^ y[(i+7)%8] ^ c[i];
        return s;
    endfunction

    function automatic logic [31:0] wmodel(input logic iv, input logic [31:0] w);
        logic [31:0] r;
        for (int b = 0; b < 4; b++) r[8*b +: 8] = iv ? rev[w[8*b +: 8]] : fwd[w[8*b +: 8]];
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", nm, got, exp);
        end
    endtask

    task automatic do_reset(input int d);
        @(negedge clk);
        rst[d] = 1'b1;
        in_valid[d] = 1'b0;
        out_ready[d] = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk($sformatf("reset valid d%0d", d), 32'(out_valid[d]), 32'd0);
        chk($sformatf("reset data d%0d", d), dout[d], 32'd0);
        chk($sformatf("reset ready d%0d", d), 32'(in_ready[d]), 32'd0);
        rst[d] = 1'b0;
        #1 chk($sformatf("post-reset ready d%0d", d), 32'(in_ready[d]), 32'd1);
    endtask

    task automatic run_op(input int d, input logic iv, input logic [31:0] w,
                          input logic [31:0] exp, input string nm);
        int cyc;
        in_valid[d] = 1'b1;
        inv[d] = iv;
        din[d] = w;
        out_ready[d] = 1'b1;
        #1 chk({nm, " ready"}, 32'(in_ready[d]), 32'd1);
        @(posedge clk);
        @(negedge clk);
        in_valid[d] = 1'b0;
        inv[d] = ~iv;
        din[d] = ~w;
        cyc = 0;
        while (!out_valid[d] && cyc < 20) begin
            chk({nm, " busy ready"}, 32'(in_ready[d]), 32'd0);
            @(negedge clk);
            cyc++;
        end
        chk({nm, " latency"}, 32'(cyc), 32'(LAT[d]));
        chk({nm, " data"}, dout[d], exp);
        @(negedge clk);
    endtask

    task automatic backpressure(input int d);
        logic [31:0] w1, w2;
        int cyc;
        w1 = $urandom;
        w2 = $urandom;
        in_valid[d] = 1'b1;
        inv[d] = 1'b0;
        din[d] = w1;
        out_ready[d] = 1'b0;
        @(posedge clk);
        @(negedge clk);
        in_valid[d] = 1'b0;
        cyc = 0;
        while (!out_valid[d] && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("bp hold valid d%0d", d), 32'(out_valid[d]), 32'd1);
            chk($sformatf("bp hold data d%0d", d), dout[d], wmodel(1'b0, w1));
            chk($sformatf("bp hold ready d%0d", d), 32'(in_ready[d]), 32'd0);
            @(negedge clk);
        end
        out_ready[d] = 1'b1;
        in_valid[d] = 1'b1;
        inv[d] = 1'b1;
        din[d] = w2;
        #1 chk($sformatf("bp same-cycle ready d%0d", d), 32'(in_ready[d]), 32'd1);
        @(posedge clk);
        @(negedge clk);
        in_valid[d] = 1'b0;
        chk($sformatf("bp valid dropped d%0d", d), 32'(out_valid[d]), 32'd0);
        cyc = 0;
        while (!out_valid[d] && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        chk($sformatf("bp next latency d%0d", d), 32'(cyc), 32'(LAT[d]));
        chk($sformatf("bp next data d%0d", d), dout[d], wmodel(1'b1, w2));
        @(negedge clk);
    endtask

    task automatic reset_busy(input int d);
        in_valid[d] = 1'b1;
        inv[d] = 1'b0;
        din[d] = $urandom;
        out_ready[d] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid[d] = 1'b0;
        rst[d] = 1'b1;
        @(negedge clk);
        chk($sformatf("abort valid d%0d", d), 32'(out_valid[d]), 32'd0);
        chk($sformatf("abort data d%0d", d), dout[d], 32'd0);
        chk($sformatf("abort ready d%0d", d), 32'(in_ready[d]), 32'd0);
        rst[d] = 1'b0;
        #1 chk($sformatf("abort idle d%0d", d), 32'(in_ready[d]), 32'd1);
        for (int k = 0; k < LAT[d] + 3; k++) begin
            @(negedge clk);
            chk($sformatf("abort no output d%0d", d), 32'(out_valid[d]), 32'd0);
        end
    endtask

    initial begin
        logic [31:0] w;
        logic        iv;
        for (int d = 0; d < N; d++) begin
            rst[d] = 1'b1;
            in_valid[d] = 1'b0;
            inv[d] = 1'b0;
            din[d] = '0;
            out_ready[d] = 1'b0;
`ifdef AES_SBOX_SM4_EN
            sm4[d] = 1'b0;
`endif
        end
        for (int x = 0; x < 256; x++) fwd[x] = sbox(8'(x));
        for (int x = 0; x < 256; x++) rev[fwd[x]] = 8'(x);
        tbl[0] = '{1'b0, 32'h00010203, 32'h637c777b};
        tbl[1] = '{1'b1, 32'h637c777b, 32'h00010203};
        tbl[2] = '{1'b0, 32'h00530053, 32'h63ed63ed};
        tbl[3] = '{1'b0, 32'hffffffff, 32'h16161616};
        tbl[4] = '{1'b1, 32'h16ed6300, 32'hff530052};
        tbl[5] = '{1'b0, 32'h52000000, 32'h00636363};
        for (int d = 0; d < N; d++) begin
            do_reset(d);
            for (int t = 0; t < 6; t++)
                run_op(d, tbl[t].iv, tbl[t].w, tbl[t].exp, $sformatf("vec%0d d%0d", t, d));
            for (int x = 0; x < 256; x++) begin
                run_op(d, 1'b0, {4{8'(x)}}, {4{fwd[x]}}, $sformatf("fwd %02h d%0d", x, d));
                run_op(d, 1'b1, {4{fwd[x]}}, {4{8'(x)}}, $sformatf("inv %02h d%0d", x, d));
            end
            for (int r = 0; r < 40; r++) begin
                w = $urandom;
                iv = 1'($urandom_range(0, 1));
                run_op(d, iv, w, wmodel(iv, w), $sformatf("rand %h/%0d d%0d", w, iv, d));
            end
            backpressure(d);
            reset_busy(d);
`ifdef AES_SBOX_SM4_EN
            sm4[d] = 1'b1;
            run_op(d, 1'b0, 32'h0, 32'hd6d6d6d6, $sformatf("sm4 d%0d", d));
            run_op(d, 1'b1, 32'h0, 32'hd6d6d6d6, $sformatf("sm4 inv-override d%0d", d));
            sm4[d] = 1'b0;
`endif
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/aes_sbox_unit.md
Name: aes_sbox_unit

Overview:
- Multi-lane, sequenced AES S-box engine for the crypto datapath: substitutes all 4 bytes of a 32-bit word, forward or inverse, using LANES shared S-box datapaths over 4/LANES steps.
- Each lane is the standard three-part Nyberg S-box: top linear layer, shared GF(256) inversion middle, bottom linear layer.
- Top and bottom layers are mode-selected; the middle layer is instantiated once per lane.
- Valid/ready handshake on both sides; sits between the crypto instruction decode and the writeback mux.

Parameters:
- LANES, 4, S-box datapaths instantiated; legal values 1, 2, 4; STEPS = 4/LANES.
- PIPE, 0, 1 inserts a register between middle and bottom layers, adding one cycle per step.

Ports:
- clk  input  1  clock
- reset  input  1  synchronous active-high reset
- in_valid_i  input  1  request valid
- in_ready_o  output  1  unit can accept a request
- inv_i  input  1  0 = forward S-box, 1 = inverse S-box
- data_i  input  32  word to substitute
- out_valid_o  output  1  result valid
- out_ready_i  input  1  consumer accepts result
- data_o  output  32  substituted word

Behaviour:
- Single clock domain (clk); reset is synchronous and active-high.
- While reset is high, all of the following hold:
  - state = IDLE
  - out_valid_o = 0, data_o = 0, in_ready_o = 0
  - step counter, operand register and mode register cleared
- Reset asserted mid-operation aborts the operation; no output is produced.
- States: IDLE, BUSY, DONE.
- in_ready_o = (state==IDLE) | (state==DONE & out_ready_i), with reset low.
- Accept = in_valid_i & in_ready_o. On accept:
  - latch data_i and inv_i
  - clear step counter
  - go to BUSY
- inv_i and data_i are ignored except at accept; mode cannot change mid-operation.
- BUSY: step k (0..STEPS-1) feeds bytes k*LANES .. k*LANES+LANES-1 (byte 0 = bits[7:0]) to the lanes.
  - PIPE=0: results written into the result register at the end of the step's cycle.
  - PIPE=1: middle-layer outputs registered, result written the following cycle.
  - Step counter increments per completed step; after step STEPS-1 completes, go to DONE.
- Latency, accept to out_valid_o rising: STEPS*(1+PIPE) cycles. Values:
  - LANES=4, PIPE=0: 1
  - LANES=1, PIPE=1: 8
- DONE:
  - out_valid_o = 1; data_o holds the full result and stays stable until out_ready_i.
  - On out_ready_i, clear out_valid_o and go to IDLE.
  - If accept occurs in the same cycle, go directly to BUSY; back-to-back issue, no bubble.
- out_valid_o is 0 in IDLE and BUSY. data_o is only guaranteed meaningful while out_valid_o=1.
- Forward result per byte: AES SubBytes.
- Inverse result per byte: AES InvSubBytes; the inverse top layer applies the inverse affine map before inversion, and the inverse bottom layer emits the inversion result.
- Inverse of forward is identity for all 256 byte values.
- in_valid_i while BUSY is ignored (in_ready_o=0); the upstream must hold the request.
- No other internal state; a request is never dropped or duplicated.

Optional Feature:
- Macro: AES_SBOX_SM4_EN.
- Defined:
  - adds port sm4_i (input, 1), latched at accept.
  - sm4_i=1 selects the SM4 top/bottom layers and overrides inv_i.
  - Timing and handshake are identical to AES.
- Undefined:
  - no sm4_i port and no SM4 layers.
  - Only AES forward/inverse is supported.

Test Plan:
- LANES=4, PIPE=0: reset, then data_i=0x00010203, inv_i=0 -> out_valid_o exactly 1 cycle after accept, data_o=0x637C777B.
- LANES=1, PIPE=1: data_i=0x637C777B, inv_i=1 -> out_valid_o 8 cycles after accept, data_o=0x00010203; in_ready_o=0 throughout BUSY.
- All configs, exhaustive sweep:
  - forward S(0x00)=0x63, S(0x53)=0xED, S(0xFF)=0x16
  - inverse S^-1(S(x))=x for all 256 bytes, replicated in all 4 byte positions
- Backpressure: hold out_ready_i=0 for 5 cycles in DONE -> data_o and out_valid_o stable; then out_ready_i=1 with a new in_valid_i -> accepted same cycle, next result with no bubble.
- Assert reset during BUSY (LANES=1) -> next cycle out_valid_o=0, data_o=0, state IDLE; no result for the aborted request.
- AES_SBOX_SM4_EN defined: sm4_i=1, data_i=0x00000000 -> data_o=0xD6D6D6D6; sm4_i=1, inv_i=1 -> identical result (SM4 overrides inv_i).
